// File: rtl/fetch_pkg.sv
// Shared types and constants for the multi-word fetch buffer.
package fetch_pkg;

   localparam int INSTR_BYTES = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic bit fetch_width_legal(input int width);
      return (width == 1) || (width == 2) || (width == 4);
   endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// Decode-side valid/ready handshake carrying one instruction and its PC.
interface fetch_buffer_if;

   logic        deq_valid;
   logic        deq_ready;
   logic [31:0] deq_instr;
   logic [31:0] deq_pc;

   modport master (output deq_valid, output deq_instr, output deq_pc, input deq_ready);
   modport slave  (input deq_valid, input deq_instr, input deq_pc, output deq_ready);

endinterface

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch entries: up to FETCH_WIDTH pushes and one pop per cycle,
// with a synchronous clear that wins over both.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int FETCH_WIDTH = 2,
   parameter int QUEUE_DEPTH = 8
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               clear,
   input  logic [$clog2(FETCH_WIDTH+1)-1:0]   enq_cnt,
   input  fetch_entry_t [FETCH_WIDTH-1:0]     enq_data,
   input  logic                               pop,
   output fetch_entry_t                       head_entry,
   output logic [$clog2(QUEUE_DEPTH):0]       count
);

   localparam int AW = $clog2(QUEUE_DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t   mem [QUEUE_DEPTH];
   logic [AW-1:0]  head;
   logic [AW-1:0]  tail;

   // Storage is reset too so the head read is all-zero while in reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < QUEUE_DEPTH; i++) mem[i] <= '0;
      end else if (clear) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (k < int'(enq_cnt)) mem[tail + AW'(k)] <= enq_data[k];
         end
         tail  <= tail + AW'(enq_cnt);
         head  <= head + AW'(pop);
         count <= count + CW'(enq_cnt) - CW'(pop);
      end
   end

   assign head_entry = mem[head];

endmodule

// File: rtl/fetch_buffer.sv
// Multi-word instruction fetch with credit-based ROM issue, redirect flush and
// end-of-program detection. Define FETCH_ZERO_STOP_EN to also stop on an all-zero word.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int          FETCH_WIDTH = 2,
   parameter int          QUEUE_DEPTH = 8,
   parameter logic [31:0] RESET_PC    = 32'h0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [31:0]                   rom_size,
   output logic [31:0]                   rom_addr,
   output logic                          rom_req,
   input  logic [32*FETCH_WIDTH-1:0]     rom_rdata,
   input  logic                          redirect_valid,
   input  logic [31:0]                   redirect_pc,
   fetch_buffer_if.master                dec,
   output logic                          fetch_complete,
   output logic [$clog2(QUEUE_DEPTH):0]  occupancy
);

   localparam int CW = $clog2(QUEUE_DEPTH) + 1;
   localparam int EW = $clog2(FETCH_WIDTH + 1);

   if (!fetch_width_legal(FETCH_WIDTH) || (QUEUE_DEPTH < 2*FETCH_WIDTH) ||
       ((QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0)) begin : g_bad_params
      $error("fetch_buffer: illegal FETCH_WIDTH / QUEUE_DEPTH combination");
   end

   logic [31:0]                   pc;
   logic [31:0]                   pend_pc;
   logic                          pend;
   logic                          done;
   logic [CW-1:0]                 q_count;
   fetch_entry_t                  head_entry;
   fetch_entry_t [FETCH_WIDTH-1:0] enq_data;
   logic [EW-1:0]                 n_enq;
   logic                          set_done;
   logic                          issue;
   logic                          pop;
   logic                          term;
   logic                          stop;
   logic [31:0]                   addr;
   logic [31:0]                   word;
   int                            credit;

   // Free slots after the in-flight group lands must hold a whole new group.
   always_comb begin
      credit = QUEUE_DEPTH - int'(q_count) - (pend ? FETCH_WIDTH : 0);
      issue  = reset && !done && !redirect_valid && (credit >= FETCH_WIDTH);
   end

   // Words past the first terminator are dropped; groups landing after done are stale.
   always_comb begin
      n_enq    = '0;
      set_done = 1'b0;
      term     = 1'b0;
      stop     = 1'b0;
      addr     = '0;
      word     = '0;
      enq_data = '0;
      if (pend && !done) begin
         for (int k = 0; k < FETCH_WIDTH; k++) begin
            addr = pend_pc + 32'(INSTR_BYTES * k);
            word = rom_rdata[32*k +: 32];
`ifdef FETCH_ZERO_STOP_EN
            stop = (addr >= rom_size) || (word == '0);
`else
            stop = (addr >= rom_size);
`endif
            if (!term) begin
               if (stop) begin
                  term     = 1'b1;
                  set_done = 1'b1;
               end else begin
                  enq_data[k] = '{pc: addr, instr: word};
                  n_enq       = n_enq + EW'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc      <= RESET_PC;
         pend    <= 1'b0;
         pend_pc <= '0;
         done    <= 1'b0;
      end else if (redirect_valid) begin
         pc   <= redirect_pc & ~32'd3;
         pend <= 1'b0;
         done <= 1'b0;
      end else begin
         pend <= issue;
         if (issue) begin
            pend_pc <= pc;
            pc      <= pc + 32'(INSTR_BYTES * FETCH_WIDTH);
         end
         if (set_done) done <= 1'b1;
      end
   end

   fetch_queue #(
      .FETCH_WIDTH (FETCH_WIDTH),
      .QUEUE_DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk        (clk),
      .reset      (reset),
      .clear      (redirect_valid),
      .enq_cnt    (n_enq),
      .enq_data   (enq_data),
      .pop        (pop),
      .head_entry (head_entry),
      .count      (q_count)
   );

   assign dec.deq_valid  = (q_count != '0) && !redirect_valid;
   assign dec.deq_instr  = head_entry.instr;
   assign dec.deq_pc     = head_entry.pc;
   assign pop            = dec.deq_valid && dec.deq_ready;

   assign rom_req        = issue;
   assign rom_addr       = pc;
   assign occupancy      = q_count;
   assign fetch_complete = done && (q_count == '0) && !pend;

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: a FETCH_WIDTH=2 and a FETCH_WIDTH=4 instance against a program-stream reference.
module tb_fetch_buffer;

   localparam logic [31:0] RST_PC  = 32'h0;
   localparam logic [31:0] NO_ZERO = 32'hFFFF_FFF0;
`ifdef FETCH_ZERO_STOP_EN
   localparam int ZERO_STREAM = 3;
`else
   localparam int ZERO_STREAM = 8;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   logic [31:0] zero_addr = NO_ZERO;

   logic [31:0]  rom_size_a = 32'd0, rom_addr_a, redirect_pc_a = 32'd0;
   logic         rom_req_a, redirect_valid_a = 1'b0, fetch_complete_a;
   logic [63:0]  rom_rdata_a = '0;
   logic [3:0]   occupancy_a;
   fetch_buffer_if if_a();

   logic [31:0]  rom_size_b = 32'd0, rom_addr_b, redirect_pc_b = 32'd0;
   logic         rom_req_b, redirect_valid_b = 1'b0, fetch_complete_b;
   logic [127:0] rom_rdata_b = '0;
   logic [3:0]   occupancy_b;
   fetch_buffer_if if_b();

   fetch_buffer #(.FETCH_WIDTH(2), .QUEUE_DEPTH(8), .RESET_PC(RST_PC)) u_dut_a (
      .clk(clk), .reset(reset), .rom_size(rom_size_a), .rom_addr(rom_addr_a),
      .rom_req(rom_req_a), .rom_rdata(rom_rdata_a), .redirect_valid(redirect_valid_a),
      .redirect_pc(redirect_pc_a), .dec(if_a), .fetch_complete(fetch_complete_a),
      .occupancy(occupancy_a));

   fetch_buffer #(.FETCH_WIDTH(4), .QUEUE_DEPTH(8), .RESET_PC(RST_PC)) u_dut_b (
      .clk(clk), .reset(reset), .rom_size(rom_size_b), .rom_addr(rom_addr_b),
      .rom_req(rom_req_b), .rom_rdata(rom_rdata_b), .redirect_valid(redirect_valid_b),
      .redirect_pc(redirect_pc_b), .dec(if_b), .fetch_complete(fetch_complete_b),
      .occupancy(occupancy_b));

   function automatic logic [31:0] word_at(input logic [31:0] addr);
      if (addr == zero_addr) return 32'h0;
      return {~addr[15:0], addr[15:0]};
   endfunction

   function automatic bit is_term(input logic [31:0] addr, input logic [31:0] size);
`ifdef FETCH_ZERO_STOP_EN
      return (addr >= size) || (word_at(addr) == 32'h0);
`else
      return addr >= size;
`endif
   endfunction

   function automatic int stream_len(input logic [31:0] start, input logic [31:0] size);
      int n = 0;
      logic [31:0] a = start;
      while (!is_term(a, size) && n < 4096) begin
         n++;
         a = a + 32'd4;
      end
      return n;
   endfunction

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= reset ? cyc + 1 : 0;

   always @(posedge clk) begin
      if (rom_req_a)
         for (int k = 0; k < 2; k++) rom_rdata_a[32*k +: 32] <= word_at(rom_addr_a + 32'(4*k));
      if (rom_req_b)
         for (int k = 0; k < 4; k++) rom_rdata_b[32*k +: 32] <= word_at(rom_addr_b + 32'(4*k));
   end

   int n_deq_a = 0, last_hs_a = 0, n_deq_b = 0;
   logic [31:0] exp_a = RST_PC, start_a = RST_PC, exp_b = RST_PC, start_b = RST_PC;

   always @(negedge clk or negedge reset) begin
      if (!reset) begin
         exp_a = RST_PC; start_a = RST_PC; n_deq_a = 0;
         exp_b = RST_PC; start_b = RST_PC; n_deq_b = 0;
      end else begin
         if (redirect_valid_a) begin
            check_val("a_redirect_deq_valid", if_a.deq_valid, 0);
            exp_a = redirect_pc_a & ~32'd3; start_a = exp_a; n_deq_a = 0;
         end else if (if_a.deq_valid && if_a.deq_ready) begin
            check_val("a_past_end", is_term(exp_a, rom_size_a), 0);
            check_val("a_deq_pc", if_a.deq_pc, exp_a);
            check_val("a_deq_instr", if_a.deq_instr, word_at(exp_a));
            exp_a = exp_a + 32'd4; n_deq_a++; last_hs_a = cyc;
         end
         if (redirect_valid_b) begin
            check_val("b_redirect_deq_valid", if_b.deq_valid, 0);
            exp_b = redirect_pc_b & ~32'd3; start_b = exp_b; n_deq_b = 0;
         end else if (if_b.deq_valid && if_b.deq_ready) begin
            check_val("b_past_end", is_term(exp_b, rom_size_b), 0);
            check_val("b_deq_pc", if_b.deq_pc, exp_b);
            check_val("b_deq_instr", if_b.deq_instr, word_at(exp_b));
            exp_b = exp_b + 32'd4; n_deq_b++;
         end
      end
   end

   task automatic do_reset(input logic [31:0] size_a, input logic [31:0] size_b,
                           input logic rdy_a, input logic rdy_b, input logic [31:0] zaddr);
      @(posedge clk); #1;
      reset = 1'b0;
      redirect_valid_a = 1'b0; redirect_valid_b = 1'b0;
      rom_size_a = size_a; rom_size_b = size_b; zero_addr = zaddr;
      if_a.deq_ready = rdy_a; if_b.deq_ready = rdy_b;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic wait_fc(input bit sel_b, input int limit, output int at_cyc);
      at_cyc = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (sel_b ? fetch_complete_b : fetch_complete_a) begin
            at_cyc = cyc;
            break;
         end
      end
      check_val(sel_b ? "b_fc_timeout" : "a_fc_timeout", at_cyc >= 0, 1);
   endtask

   task automatic check_reset_outputs();
      check_val("rst_a_rom_req", rom_req_a, 0);
      check_val("rst_a_deq_valid", if_a.deq_valid, 0);
      check_val("rst_a_fc", fetch_complete_a, 0);
      check_val("rst_a_occ", occupancy_a, 0);
      check_val("rst_a_instr", if_a.deq_instr, 0);
      check_val("rst_a_pc", if_a.deq_pc, 0);
      check_val("rst_b_rom_req", rom_req_b, 0);
      check_val("rst_b_deq_valid", if_b.deq_valid, 0);
      check_val("rst_b_occ", occupancy_b, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int fc_cyc;
      if_a.deq_ready = 1'b1;
      if_b.deq_ready = 1'b0;
      rom_size_a = 32'd24;
      rom_size_b = 32'd10;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs();

      // Straight-line program: 6 words, 2-cycle fetch-to-decode latency.
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      check_val("c0_rom_req", rom_req_a, 1);
      check_val("c0_rom_addr", rom_addr_a, RST_PC);
      check_val("c0_deq_valid", if_a.deq_valid, 0);
      @(negedge clk);
      check_val("c1_deq_valid", if_a.deq_valid, 0);
      @(negedge clk);
      check_val("c2_deq_valid", if_a.deq_valid, 1);
      check_val("c2_deq_pc", if_a.deq_pc, 0);
      wait_fc(1'b0, 40, fc_cyc);
      check_val("fc_cycle", fc_cyc, 8);
      check_val("fc_after_last_hs", fc_cyc, last_hs_a + 1);
      check_val("a_count_24", n_deq_a, 6);

      // FETCH_WIDTH=4 with rom_size=10 holds exactly three entries.
      check_val("b_occ_10", occupancy_b, 3);
      check_val("b_fc_while_full", fetch_complete_b, 0);
      if_b.deq_ready = 1'b1;
      wait_fc(1'b1, 40, fc_cyc);
      check_val("b_count_10", n_deq_b, 3);

      // Backpressure saturates the queue and stops issue.
      do_reset(32'd200, 32'd10, 1'b0, 1'b1, NO_ZERO);
      repeat (12) @(negedge clk);
      check_val("bp_occ", occupancy_a, 8);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_val("bp_no_req", rom_req_a, 0);
      end
      @(posedge clk); #1 if_a.deq_ready = 1'b1;
      wait_fc(1'b0, 300, fc_cyc);
      check_val("bp_count", n_deq_a, 50);

      // Redirect with 5 queued entries and a read in flight.
      do_reset(32'd200, 32'd10, 1'b0, 1'b1, NO_ZERO);
      @(posedge clk); #1;
      @(posedge clk); #1 if_a.deq_ready = 1'b1;
      @(posedge clk); #1 if_a.deq_ready = 1'b0;
      @(negedge clk);
      check_val("rd_inflight_req", rom_req_a, 1);
      @(posedge clk); #1;
      redirect_valid_a = 1'b1; redirect_pc_a = 32'h0A;
      @(negedge clk);
      check_val("rd_occ_before", occupancy_a, 5);
      check_val("rd_no_issue", rom_req_a, 0);
      @(posedge clk); #1;
      redirect_valid_a = 1'b0; if_a.deq_ready = 1'b1;
      @(negedge clk);
      check_val("rd_next_req", rom_req_a, 1);
      check_val("rd_next_addr", rom_addr_a, 32'h08);
      @(negedge clk);
      check_val("rd_t2_valid", if_a.deq_valid, 0);
      @(negedge clk);
      check_val("rd_t3_valid", if_a.deq_valid, 1);
      check_val("rd_t3_pc", if_a.deq_pc, 32'h08);
      wait_fc(1'b0, 300, fc_cyc);
      check_val("rd_count", n_deq_a, 48);

      // Zero word at 0x0C.
      do_reset(32'd32, 32'd10, 1'b0, 1'b1, 32'h0C);
      repeat (10) @(negedge clk);
      check_val("zero_occ", occupancy_a, ZERO_STREAM);
      @(posedge clk); #1 if_a.deq_ready = 1'b1;
      wait_fc(1'b0, 100, fc_cyc);
      check_val("zero_count", n_deq_a, ZERO_STREAM);

      // Asynchronous reset mid-stream.
      do_reset(32'd200, 32'd10, 1'b1, 1'b1, NO_ZERO);
      repeat (6) @(negedge clk);
      #1 reset = 1'b0;
      #1 check_reset_outputs();
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      check_val("rs_a_req", rom_req_a, 1);
      check_val("rs_a_addr", rom_addr_a, RST_PC);
      check_val("rs_b_addr", rom_addr_b, RST_PC);
      wait_fc(1'b0, 300, fc_cyc);
      check_val("rs_count", n_deq_a, 50);

      // Randomized sizes, backpressure, redirects and zero words.
      for (int r = 0; r < 8; r++) begin
         do_reset($urandom_range(4, 120), $urandom_range(4, 120),
                  1'b1, 1'b1, ($urandom % 2) ? 32'($urandom_range(0, 24) * 4) : NO_ZERO);
         for (int i = 0; i < 150; i++) begin
            @(posedge clk); #1;
            if_a.deq_ready   = ($urandom % 4) != 0;
            if_b.deq_ready   = ($urandom % 2) != 0;
            redirect_valid_a = ($urandom % 30) == 0;
            redirect_pc_a    = $urandom_range(0, 110);
            redirect_valid_b = ($urandom % 30) == 0;
            redirect_pc_b    = $urandom_range(0, 110);
         end
         @(posedge clk); #1;
         redirect_valid_a = 1'b0; redirect_valid_b = 1'b0;
         if_a.deq_ready = 1'b1; if_b.deq_ready = 1'b1;
         wait_fc(1'b0, 300, fc_cyc);
         check_val("rnd_a_count", n_deq_a, stream_len(start_a, rom_size_a));
         wait_fc(1'b1, 300, fc_cyc);
         check_val("rnd_b_count", n_deq_b, stream_len(start_b, rom_size_b));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Parametrised successor to the single-word fetch stage. Fetches up to `FETCH_WIDTH` consecutive instructions per cycle from a synchronous instruction ROM and buffers them in a circular queue. Hands them one at a time to decode over a valid/ready handshake. Supports PC redirect with flush and a registered end-of-program indication; sits between the instruction ROM and the decode stage in the top level.

## Interface
- `FETCH_WIDTH`, 2: instructions read per ROM access; legal values 1, 2, 4.
- `QUEUE_DEPTH`, 8: queue entries; power of two, at least `2*FETCH_WIDTH`.
- `RESET_PC`, 32'h0: PC loaded at reset.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `rom_size` in 32: program size in bytes; stable while out of reset.
- `rom_addr` out 32: byte address of the first word of the current ROM read.
- `rom_req` out 1: ROM read issued this cycle.
- `rom_rdata` in `32*FETCH_WIDTH`: word k is at `[32k +: 32]`; valid exactly 1 cycle after `rom_req`.
- `redirect_valid` in 1: flush and restart fetch this cycle.
- `redirect_pc` in 32: new PC; bits [1:0] ignored (treated as 0).
- `deq_valid` out 1: head entry available.
- `deq_ready` in 1: decode accepts the head entry.
- `deq_instr` out 32: head instruction.
- `deq_pc` out 32: head PC.
- `fetch_complete` out 1: end of program reached and queue empty.
- `occupancy` out `$clog2(QUEUE_DEPTH)+1`: current queue entry count.

## Operation
- State: `pc`, `pend` (read in flight), `pend_pc`, `done`, and the queue (`head`, `tail`, `count`).
- Issue condition: `!done && !redirect_valid && (QUEUE_DEPTH - count - (pend ? FETCH_WIDTH : 0)) >= FETCH_WIDTH`, using the registered `count`.
- On issue:
  - `rom_req=1`, `rom_addr=pc`.
  - `pend<=1`, `pend_pc<=pc`, `pc<=pc+4*FETCH_WIDTH` (32-bit wrap).
- Response cycle (`pend=1`): word k has address `pend_pc+4k`.
  - Word k is enqueued iff its address is below `rom_size` and no earlier word in the group terminated.
  - The first word at or past `rom_size` sets `done`.
  - Enqueued words are written in order from `tail`.
- Dequeue: a handshake occurs when `deq_valid && deq_ready`; `head` advances by 1.
- Same-cycle enqueue and dequeue: `count <= count + n_enq - 1`.
- Queue full: the issue condition guarantees a response always fits, so no overflow is possible. Empty queue: `deq_valid=0`.
- Redirect has priority over every other event:
  - Queue is cleared (`head=tail=count=0`).
  - `pend<=0`; any in-flight response is discarded.
  - `done<=0`, `pc<=redirect_pc&~3`.
  - `deq_valid` is forced to 0 in the redirect cycle.
  - No issue occurs in the redirect cycle.
- `fetch_complete = done && count==0 && !pend`.

## Timing
- Reset (asynchronous assert) values:
  - `pc=RESET_PC`, `pend=0`, `done=0`, `count=0`.
  - Outputs: `rom_req=0`, `deq_valid=0`, `fetch_complete=0`, `occupancy=0`, `deq_instr=0`, `deq_pc=0`.
- Reset assertion mid-operation discards all in-flight state immediately.
- First issue occurs in the first cycle after reset deassertion (cycle 0).
  - Response in cycle 1; entries are written at the end of cycle 1.
  - `deq_valid=1` from cycle 2 (fetch-to-decode latency is 2 cycles).
- Steady state: one issue per cycle while the credit condition holds.
- `deq_instr`/`deq_pc` are combinational reads of the head entry. They hold while `deq_valid && !deq_ready`.
- After a redirect in cycle t: the first issue is in t+1 and `deq_valid` rises in t+3.

## Configuration
- `FETCH_ZERO_STOP_EN` defined:
  - An all-zero instruction word is also a terminator: it is not enqueued, sets `done`, and suppresses later words in its group.
- Not defined:
  - Only `rom_size` terminates fetch.
  - Zero words are enqueued as ordinary instructions.

## Structure
- Package `fetch_pkg`:
  - `fetch_entry_t` {`pc[31:0]`, `instr[31:0]`}.
  - Constant `INSTR_BYTES=4`.
  - Function for the legal `FETCH_WIDTH` check.
- Sub-module `fetch_queue`:
  - Circular FIFO of `fetch_entry_t` with 0..`FETCH_WIDTH` enqueues and 0..1 dequeue per cycle, plus a synchronous clear.
  - `fetch_buffer` owns the PC, credit and termination logic.

## Test plan
- `FETCH_WIDTH=2`, `rom_size=24`, `deq_ready=1`:
  - Six instructions dequeued in order with `deq_pc` 0,4,…,20.
  - First `deq_valid` at cycle 2.
  - `fetch_complete=1` one cycle after the last handshake.
- Backpressure with `deq_ready=0` held:
  - `occupancy` saturates at 8, with no `rom_req` once credit is exhausted.
  - Release `deq_ready`: no entry is lost or duplicated.
- Redirect to `0x0A` while the queue holds 5 entries and a read is in flight:
  - Next `rom_addr=0x08`; the stale response is dropped.
  - First dequeued `deq_pc=0x08`.
- `rom_size=10` with `FETCH_WIDTH=4`: exactly words 0 and 4 and 8 are enqueued (3 entries), then `done`.
- With `FETCH_ZERO_STOP_EN`, a zero word at `0x0C` and `rom_size=32`:
  - Only 3 instructions are enqueued.
  - Without the macro, all 8 are enqueued.
- Assert `reset` low mid-stream: all outputs return to their reset values in the same cycle, and fetch restarts at `RESET_PC`.
